// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path, the frame buffer and the display.
// Contents:
//   cam_state_e    capture FSM state encoding
//   Rgb565*        bit positions of the colour fields in a {byte0, byte1} RGB565 word
//   cam_clog2      ceil(log2(value)), usable in localparam expressions
package cam_pkg;

  typedef enum logic [1:0] {
    StWaitVs,     // waiting for vsync to go high
    StWaitStart,  // vsync high, waiting for its falling edge
    StActive      // capturing a frame
  } cam_state_e;

  localparam int unsigned Rgb565RedMsb   = 15;
  localparam int unsigned Rgb565RedLsb   = 11;
  localparam int unsigned Rgb565GreenMsb = 10;
  localparam int unsigned Rgb565GreenLsb = 5;
  localparam int unsigned Rgb565BlueMsb  = 4;
  localparam int unsigned Rgb565BlueLsb  = 0;

  function automatic int unsigned cam_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = unsigned'(i) + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for one asynchronous bit, plus rising/falling edge detection on the
// synchronised value through one further flop.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset; all flops clear to 0
//   din_i   asynchronous input
//   level_o synchronised level
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
module cam_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/cam_capture_scaler.sv
// Camera capture front end: synchronises a parallel camera bus (pclk/vsync/href/data) into
// the clk domain, assembles two-byte pixels, decimates by 2**C_DS_LOG2 in both axes, reduces
// colour depth and emits frame-buffer writes.
// Ports:
//   clk, rst_n               system clock, asynchronous active-low reset
//   pclk, vsync, href, data  raw camera bus, asynchronous to clk
//   rgbmode                  1: RGB565 input, 0: YUV422 input stored as grey
//   swap_r_b                 exchange red and blue output fields
//   freeze_req               stop writing; sampled at each vsync rising edge
//   addr, dout, we           frame-buffer write port
//   frame_done, frame_cnt    complete-frame pulse and 8-bit wrapping count
//   frozen, overflow         freeze status, sticky frame-buffer overflow flag
module cam_capture_scaler
  import cam_pkg::*;
#(
  parameter int unsigned C_IN_COLS  = 640,
  parameter int unsigned C_IN_ROWS  = 480,
  parameter int unsigned C_DS_LOG2  = 2,
  parameter int unsigned C_NB_RED   = 4,
  parameter int unsigned C_NB_GREEN = 4,
  parameter int unsigned C_NB_BLUE  = 4,
  parameter int unsigned C_NB_ADDR  = 15
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     pclk,
  input  logic                                     vsync,
  input  logic                                     href,
  input  logic [7:0]                               data,
  input  logic                                     rgbmode,
  input  logic                                     swap_r_b,
  input  logic                                     freeze_req,
  output logic [C_NB_ADDR-1:0]                     addr,
  output logic [C_NB_RED+C_NB_GREEN+C_NB_BLUE-1:0] dout,
  output logic                                     we,
  output logic                                     frame_done,
  output logic                                     frozen,
  output logic [7:0]                               frame_cnt,
  output logic                                     overflow
);

  localparam int unsigned OutCols = C_IN_COLS >> C_DS_LOG2;
  localparam int unsigned OutRows = C_IN_ROWS >> C_DS_LOG2;
  localparam int unsigned OutPxls = OutCols * OutRows;
  localparam int unsigned ColW    = cam_clog2(C_IN_COLS) + 1;
  localparam int unsigned RowW    = cam_clog2(C_IN_ROWS) + 1;
  localparam int unsigned PixW    = C_NB_RED + C_NB_GREEN + C_NB_BLUE;

  localparam logic [ColW-1:0]      ColMask  = ColW'((32'd1 << C_DS_LOG2) - 32'd1);
  localparam logic [RowW-1:0]      RowMask  = RowW'((32'd1 << C_DS_LOG2) - 32'd1);
  localparam logic [C_NB_ADDR:0]   OutPxlsW = (C_NB_ADDR + 1)'(OutPxls);

  // Keep the top n bits of a left-aligned 8-bit field, zeroing the rest.
  function automatic logic [7:0] msb_keep(input logic [7:0] v, input int unsigned n);
    return v & ~(8'hFF >> n);
  endfunction

  // Input synchronisers
  logic pclk_level, pclk_rise, pclk_fall;
  logic href_level, href_rise, href_fall;
  logic vsync_level, vsync_rise, vsync_fall;
  logic [7:0] data_meta_q, data_sync_q;

  cam_sync_edge u_sync_pclk (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .din_i   (pclk),
    .level_o (pclk_level),
    .rise_o  (pclk_rise),
    .fall_o  (pclk_fall)
  );

  cam_sync_edge u_sync_href (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .din_i   (href),
    .level_o (href_level),
    .rise_o  (href_rise),
    .fall_o  (href_fall)
  );

  cam_sync_edge u_sync_vsync (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .din_i   (vsync),
    .level_o (vsync_level),
    .rise_o  (vsync_rise),
    .fall_o  (vsync_fall)
  );

  logic unused_edges;
  assign unused_edges = pclk_level ^ pclk_fall ^ href_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      data_meta_q <= data;
      data_sync_q <= data_meta_q;
    end
  end

  // Capture FSM
  cam_state_e state_q, state_d;
  logic       start_frame, end_frame, capture_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitVs;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWaitVs:    if (vsync_level) state_d = StWaitStart;
      StWaitStart: if (vsync_fall)  state_d = StActive;
      StActive:    if (vsync_rise)  state_d = StWaitStart;
      default:                      state_d = StWaitVs;
    endcase
  end

  // A vsync rise ends the frame and masks any coincident href/pclk activity.
  always_comb begin
    start_frame = 1'b0;
    end_frame   = 1'b0;
    capture_en  = 1'b0;
    case (state_q)
      StWaitStart: start_frame = vsync_fall;
      StActive: begin
        end_frame  = vsync_rise;
        capture_en = ~vsync_rise;
      end
      default: ;
    endcase
  end

  // Pixel assembly and decimation counters
  logic [ColW-1:0]      col_q;
  logic [RowW-1:0]      row_q;
  logic                 phase_q;
  logic [7:0]           byte0_q;
  logic                 byte_strobe, pixel_kept;
  logic [C_NB_ADDR-1:0] addr_q;
  logic                 we_q, frame_done_q, frozen_q, overflow_q;
  logic [7:0]           frame_cnt_q;
  logic [PixW-1:0]      dout_q;

  assign byte_strobe = capture_en & pclk_rise & href_level;
  assign pixel_kept  = ((col_q & ColMask) == '0) && ((row_q & RowMask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
      byte0_q <= '0;
    end else if (start_frame) begin
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
    end else if (capture_en && href_fall) begin
      row_q   <= row_q + RowW'(1);
      col_q   <= '0;
      phase_q <= 1'b0;
    end else if (byte_strobe) begin
      phase_q <= ~phase_q;
      if (!phase_q) begin
        byte0_q <= data_sync_q;
      end else begin
        col_q <= col_q + ColW'(1);
      end
    end
  end

  // Three pipeline stages ahead of the output register give the fixed write latency.
  logic            s1_valid_q, s2_valid_q, s3_valid_q;
  logic [15:0]     s1_pix_q;
  logic [7:0]      s2_r_q, s2_g_q, s2_b_q;
  logic [PixW-1:0] s3_pix_q;
  logic [7:0]      r_al, g_al, b_al, r_out_al, b_out_al;

  // Fields are kept MSB-aligned in 8 bits so truncation and zero-padding fall out naturally.
  always_comb begin
    if (rgbmode) begin
      r_al = {s1_pix_q[Rgb565RedMsb:Rgb565RedLsb], 3'b000};
      g_al = {s1_pix_q[Rgb565GreenMsb:Rgb565GreenLsb], 2'b00};
      b_al = {s1_pix_q[Rgb565BlueMsb:Rgb565BlueLsb], 3'b000};
    end else begin
      r_al = s1_pix_q[7:0];
      g_al = s1_pix_q[7:0];
      b_al = s1_pix_q[7:0];
    end
    r_out_al = swap_r_b ? s2_b_q : s2_r_q;
    b_out_al = swap_r_b ? s2_r_q : s2_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_g_q     <= '0;
      s2_b_q     <= '0;
      s3_valid_q <= 1'b0;
      s3_pix_q   <= '0;
    end else begin
      s1_valid_q <= byte_strobe & phase_q & pixel_kept;
      if (byte_strobe && phase_q) begin
        s1_pix_q <= {byte0_q, data_sync_q};
      end
      s2_valid_q <= s1_valid_q;
      s2_r_q     <= msb_keep(r_al, C_NB_RED);
      s2_g_q     <= msb_keep(g_al, C_NB_GREEN);
      s2_b_q     <= msb_keep(b_al, C_NB_BLUE);
      s3_valid_q <= s2_valid_q;
      s3_pix_q   <= {r_out_al[7 -: C_NB_RED], s2_g_q[7 -: C_NB_GREEN], b_out_al[7 -: C_NB_BLUE]};
    end
  end

  // Write port, frame accounting and status
  logic addr_room, addr_full, frame_complete;

  assign addr_room      = {1'b0, addr_q} < OutPxlsW;
  assign addr_full      = {1'b0, addr_q} == OutPxlsW;
  assign frame_complete = end_frame & addr_full & ~frozen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      we_q         <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      frozen_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      we_q         <= s3_valid_q & addr_room & ~frozen_q;
      frame_done_q <= frame_complete;
      if (s3_valid_q && addr_room && !frozen_q) begin
        dout_q <= s3_pix_q;
      end
      if (s3_valid_q && addr_full) begin
        overflow_q <= 1'b1;
      end
      if (start_frame) begin
        addr_q <= '0;
      end else if (we_q) begin
        addr_q <= addr_q + C_NB_ADDR'(1);
      end
      if (frame_complete) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      if (vsync_rise) begin
        frozen_q <= freeze_req;
      end
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign frozen     = frozen_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cam_capture_scaler.sv
// Directed frame sequence with random pixel bytes, checked against a frame-level model of the
// capture rules (decimation, address allocation, colour reduction, freeze and frame accounting).
module tb_cam_capture_scaler;

  localparam int COLS = 20;
  localparam int ROWS = 12;
  localparam int DS   = 1;
  localparam int NBR  = 5;
  localparam int NBG  = 4;
  localparam int NBB  = 3;
  localparam int NBA  = 6;
  localparam int D    = 1 << DS;
  localparam int OUT  = (COLS >> DS) * (ROWS >> DS);
  localparam int LAT  = 6;  // pclk driven high -> we seen: 2 sync flops + 4 clk

  logic                   clk = 1'b0;
  logic                   rst_n, pclk, vsync, href, rgbmode, swap_r_b, freeze_req;
  logic [7:0]             data;
  logic [NBA-1:0]         addr;
  logic [NBR+NBG+NBB-1:0] dout;
  logic                   we, frame_done, frozen, overflow;
  logic [7:0]             frame_cnt;

  cam_capture_scaler #(
    .C_IN_COLS  (COLS),
    .C_IN_ROWS  (ROWS),
    .C_DS_LOG2  (DS),
    .C_NB_RED   (NBR),
    .C_NB_GREEN (NBG),
    .C_NB_BLUE  (NBB),
    .C_NB_ADDR  (NBA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pclk       (pclk),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .rgbmode    (rgbmode),
    .swap_r_b   (swap_r_b),
    .freeze_req (freeze_req),
    .addr       (addr),
    .dout       (dout),
    .we         (we),
    .frame_done (frame_done),
    .frozen     (frozen),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_raise = 0;
  int done_seen = 0;
  int got_addr[$], got_dout[$], got_cyc[$];
  int exp_addr[$], exp_dout[$], exp_cyc[$];

  // Model state
  bit m_active, m_frozen, m_ovf;
  int m_addr, m_cnt, exp_done;
  logic [7:0] pb0, pb1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      got_addr.push_back(int'(addr));
      got_dout.push_back(int'(dout));
      got_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) done_seen++;
  end

  function automatic int rescale(input int v, input int from, input int to);
    return (to >= from) ? (v << (to - from)) : (v >> (from - to));
  endfunction

  function automatic int exp_pix(input int b0, input int b1, input bit rgb, input bit swp);
    int r, g, b, ro, bo;
    if (rgb) begin
      r = (b0 >> 3) >> (5 - NBR);
      g = (((b0 & 7) << 3) | (b1 >> 5)) >> (6 - NBG);
      b = (b1 & 31) >> (5 - NBB);
    end else begin
      r = b1 >> (8 - NBR);
      g = b1 >> (8 - NBG);
      b = b1 >> (8 - NBB);
    end
    ro = swp ? rescale(b, NBB, NBR) : r;
    bo = swp ? rescale(r, NBR, NBB) : b;
    return (ro << (NBG + NBB)) | (g << NBB) | bo;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".addr"}, 32'(addr), 0);
    chk({tag, ".dout"}, 32'(dout), 0);
    chk({tag, ".we"}, 32'(we), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, ".overflow"}, 32'(overflow), 0);
    chk({tag, ".frozen"}, 32'(frozen), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(1);
    chk_reset_outputs("reset_mid");
    tick(2);
    rst_n = 1'b1;
    m_active = 1'b0;
    m_frozen = 1'b0;
    m_ovf    = 1'b0;
    m_cnt    = 0;
    m_addr   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    tick(1);
    pclk = 1'b1;
    last_raise = cyc;
    tick(2);
    pclk = 1'b0;
    tick(1);
  endtask

  // Frame boundary: vsync high then low; the rise closes the current frame.
  task automatic vs_pulse();
    vsync = 1'b1;
    if (m_active && m_addr == OUT && !m_frozen) begin
      exp_done++;
      m_cnt = (m_cnt + 1) % 256;
    end
    m_frozen = freeze_req;
    m_active = 1'b0;
    tick(8);
    vsync = 1'b0;
    tick(8);
    m_active = 1'b1;
    m_addr   = 0;
  endtask

  task automatic send_lines(input int rows, input bit rnd, input int frz_row, input bit frz_val,
                            input int rst_row);
    for (int r = 0; r < rows; r++) begin
      if (r == frz_row) freeze_req = frz_val;
      if (r == rst_row) pulse_reset();
      href = 1'b1;
      tick(2);
      for (int c = 0; c < COLS; c++) begin
        logic [7:0] b0, b1;
        b0 = rnd ? 8'($urandom_range(255)) : pb0;
        b1 = rnd ? 8'($urandom_range(255)) : pb1;
        send_byte(b0);
        send_byte(b1);
        if (m_active && (r % D == 0) && (c % D == 0)) begin
          if (m_addr < OUT) begin
            if (!m_frozen) begin
              exp_addr.push_back(m_addr);
              exp_dout.push_back(exp_pix(int'(b0), int'(b1), rgbmode, swap_r_b));
              exp_cyc.push_back(last_raise);
              m_addr++;
            end
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      href = 1'b0;
      tick(6);
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, ".n_writes"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.addr[%0d]", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      chk($sformatf("%s.dout[%0d]", tag, i), 32'(got_dout[i]), 32'(exp_dout[i]));
      chk($sformatf("%s.latency[%0d]", tag, i), 32'(got_cyc[i] - exp_cyc[i]), LAT);
    end
    chk({tag, ".frame_done_count"}, 32'(done_seen), 32'(exp_done));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".frozen"}, 32'(frozen), 32'(m_frozen));
    got_addr.delete(); got_dout.delete(); got_cyc.delete();
    exp_addr.delete(); exp_dout.delete(); exp_cyc.delete();
  endtask

  initial begin
    rst_n = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = '0;
    rgbmode = 1'b1; swap_r_b = 1'b0; freeze_req = 1'b0;
    m_active = 1'b0; m_frozen = 1'b0; m_ovf = 1'b0; m_addr = 0; m_cnt = 0; exp_done = 0;
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(3);
    vs_pulse();

    // Fixed RGB pattern, full frame
    pb0 = 8'hF8; pb1 = 8'h1F;
    send_lines(ROWS, 1'b0, -1, 1'b0, -1);
    chk("rgb_fixed.last_addr",
        (got_addr.size() > 0) ? 32'(got_addr[got_addr.size() - 1]) : 32'hFFFF_FFFF, OUT - 1);
    vs_pulse();
    check_frame("rgb_fixed");

    // Red/blue swap with fixed bytes
    swap_r_b = 1'b1; pb0 = 8'hF8; pb1 = 8'h00;
    send_lines(ROWS, 1'b0, -1, 1'b0, -1);
    vs_pulse();
    check_frame("swap_fixed");

    // YUV grey with fixed luma
    swap_r_b = 1'b0; rgbmode = 1'b0; pb0 = 8'h3C; pb1 = 8'hA5;
    send_lines(ROWS, 1'b0, -1, 1'b0, -1);
    vs_pulse();
    check_frame("yuv_fixed");

    // Random RGB
    rgbmode = 1'b1;
    send_lines(ROWS, 1'b1, -1, 1'b0, -1);
    vs_pulse();
    check_frame("rgb_rand");

    // Random YUV with swap; freeze requested mid-frame, frame still written
    rgbmode = 1'b0; swap_r_b = 1'b1;
    send_lines(ROWS, 1'b1, 5, 1'b1, -1);
    vs_pulse();
    check_frame("freeze_req");

    // Frozen frame, released mid-frame
    rgbmode = 1'b1; swap_r_b = 1'b0;
    send_lines(ROWS, 1'b1, 5, 1'b0, -1);
    vs_pulse();
    check_frame("frozen");

    // Writes resume
    send_lines(ROWS, 1'b1, -1, 1'b0, -1);
    vs_pulse();
    check_frame("resume");

    // One extra line overflows the buffer
    send_lines(ROWS + 1, 1'b1, -1, 1'b0, -1);
    vs_pulse();
    check_frame("overflow");

    // Short frame: no frame_done
    send_lines(ROWS / 2, 1'b1, -1, 1'b0, -1);
    vs_pulse();
    check_frame("short");

    // Reset mid-frame: no writes until a full vsync high/low sequence
    send_lines(ROWS, 1'b1, -1, 1'b0, 5);
    vs_pulse();
    check_frame("reset_mid");

    // Full frame after reset
    swap_r_b = 1'b1;
    send_lines(ROWS, 1'b1, -1, 1'b0, -1);
    vs_pulse();
    check_frame("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
